// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and occupancy width for the skid pipeline stage
package pipe_pkg;
  typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_e;
  localparam int PIPE_OCC_W = 2;
endpackage

// File: rtl/pipe_skid.sv
// pipe_skid: two-entry skid buffer; pin_ready comes straight from a flop to cut the ready chain
module pipe_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              pin_valid,
  output logic              pin_ready,
  input  logic [DATA_W-1:0] pin_data,
  output logic              pout_valid,
  input  logic              pout_ready,
  output logic [DATA_W-1:0] pout_data
);
  pipe_state_e state, state_n;
  logic [DATA_W-1:0] skid_data;
  logic skid_valid, in_fire, out_fire, main_ld, main_from_skid, skid_ld;
  assign skid_valid = ~pin_ready;
  // next state and load enables; flush wins over any handshake in the same cycle
  always_comb begin
    in_fire        = pin_valid & pin_ready;
    out_fire       = pout_valid & pout_ready;
    state_n        = flush ? PS_EMPTY :
                     state == PS_EMPTY ? (in_fire ? PS_BUSY : PS_EMPTY) :
                     state == PS_BUSY  ? (in_fire & ~out_fire ? PS_FULL :
                                          ~in_fire & out_fire ? PS_EMPTY : PS_BUSY) :
                     (out_fire ? PS_BUSY : PS_FULL);
    main_ld        = ~flush & in_fire & (state == PS_EMPTY | out_fire);
    main_from_skid = ~flush & out_fire & (state == PS_FULL);
    skid_ld        = ~flush & in_fire & ~out_fire & (state == PS_BUSY);
  end
  // control flops; valid/ready are registered decodes of the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PS_EMPTY;
      pout_valid <= 1'b0;
      pin_ready  <= 1'b1;
    end else begin
      state      <= state_n;
      pout_valid <= state_n != PS_EMPTY;
      pin_ready  <= state_n != PS_FULL;
    end
  end
  // payload flops move only on a handshake so data holds while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pout_data <= '0;
      skid_data <= '0;
    end else begin
      if (main_ld) pout_data <= pin_data;
      else if (main_from_skid) pout_data <= skid_data;
      if (skid_ld) skid_data <= pin_data;
    end
  end
`ifndef SYNTHESIS
  logic [PIPE_OCC_W-1:0] occ;
  assign occ = {1'b0, pout_valid} + {1'b0, skid_valid};
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
    pout_valid && !pout_ready && !flush |=> $stable(pout_valid) && $stable(pout_data));
  a_skid_main: assert property (@(posedge clk) disable iff (!rst) skid_valid |-> pout_valid);
  a_occ: assert property (@(posedge clk) disable iff (!rst) occ <= 2'd2);
`endif
endmodule

// File: tb/tb_pipe_skid.sv
// tb_pipe_skid: directed and randomized checks of pipe_skid against a queue-based model
module tb_pipe_skid;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        pin_valid = 1'b0;
  logic        pin_ready;
  logic [31:0] pin_data = '0;
  logic        pout_valid;
  logic        pout_ready = 1'b0;
  logic [31:0] pout_data;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  pipe_skid #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pin_valid(pin_valid), .pin_ready(pin_ready), .pin_data(pin_data),
    .pout_valid(pout_valid), .pout_ready(pout_ready), .pout_data(pout_data)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs, advance the FIFO model across the edge, land on the next negedge
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic acc, pop;
    pin_valid = v; pin_data = d; pout_ready = r; flush = f;
    acc = v && (q.size() < 2);
    pop = r && (q.size() > 0);
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", pout_valid); end
    checks++; if (pin_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", pin_ready); end
    checks++; if (pout_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", pout_data); end
    rst = 1'b1;
    q.delete();
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      checks++; if (pin_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %0b want 1", i, pin_ready); end
      checks++; if (pout_valid !== 1'b1 || pout_data !== 32'(i)) begin errors++; $display("FAIL stream_out[%0d] got v=%0b d=%h want v=1 d=%h", i, pout_valid, pout_data, i); end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", pout_valid); end
  endtask

  task automatic test_stall();
    step(1'b1, 32'hA, 1'b0, 1'b0);
    checks++; if (pin_ready !== 1'b1 || pout_data !== 32'hA) begin errors++; $display("FAIL stall_first got r=%0b d=%h want r=1 d=a", pin_ready, pout_data); end
    step(1'b1, 32'hB, 1'b0, 1'b0);
    checks++; if (pin_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b want 0", pin_ready); end
    step(1'b1, 32'hD, 1'b0, 1'b0);
    checks++; if (pout_valid !== 1'b1 || pout_data !== 32'hA) begin errors++; $display("FAIL stall_hold got v=%0b d=%h want v=1 d=a", pout_valid, pout_data); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (pout_valid !== 1'b1 || pout_data !== 32'hB || pin_ready !== 1'b1) begin errors++; $display("FAIL stall_second got v=%0b d=%h r=%0b want v=1 d=b r=1", pout_valid, pout_data, pin_ready); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %0b want 0", pout_valid); end
  endtask

  task automatic test_flush();
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h12, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    checks++; if (pout_valid !== 1'b0 || pin_ready !== 1'b1) begin errors++; $display("FAIL flush_full got v=%0b r=%0b want v=0 r=1", pout_valid, pin_ready); end
    checks++; if (pout_data === 32'hC) begin errors++; $display("FAIL flush_data got %h want not c", pout_data); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %0b want 0", pout_valid); end
    step(1'b1, 32'h21, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b1, 1'b1);
    checks++; if (pout_valid !== 1'b0 || pin_ready !== 1'b1) begin errors++; $display("FAIL flush_busy got v=%0b r=%0b want v=0 r=1", pout_valid, pin_ready); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h31, 1'b0, 1'b0);
    step(1'b1, 32'h32, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if (pout_valid !== 1'b0 || pin_ready !== 1'b1) begin errors++; $display("FAIL areset_now got v=%0b r=%0b want v=0 r=1", pout_valid, pin_ready); end
    q.delete();
    pin_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    step(1'b1, 32'h5A, 1'b1, 1'b0);
    checks++; if (pout_valid !== 1'b1 || pout_data !== 32'h5A) begin errors++; $display("FAIL areset_first got v=%0b d=%h want v=1 d=5a", pout_valid, pout_data); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (pout_valid !== 1'b0) begin errors++; $display("FAIL areset_drain got %0b want 0", pout_valid); end
  endtask

  task automatic test_random();
    logic pr;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      checks++; if (pout_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d] got %0b want %0b", i, pout_valid, q.size() > 0); end
      checks++; if (pin_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_ready[%0d] got %0b want %0b", i, pin_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if (pout_data !== q[0]) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, pout_data, q[0]); end
      end
      pr = pin_ready;
      pout_ready = ~pout_ready;
      #1;
      checks++; if (pin_ready !== pr) begin errors++; $display("FAIL rand_comb[%0d] got %0b want %0b", i, pin_ready, pr); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
